// File: rtl/qtree_level_stage.sv
// qtree_level_stage
// -----------------
// One search level of the quadtree lookup engine. A lookup carries a node
// address and a key. The stage reads the addressed 3-key node from its local
// RAM, counts how many node keys the lookup key is greater than or equal to
// (giving child 0..3), appends that 2-bit child to the address and forwards
// {next_addr, key} plus the bypass sideband to the next level.
//
// Ports
//   clk_i           clock, rising edge
//   rst_i           asynchronous active-low reset, clears all pipeline registers
//   mm_ram_data_i   node write data {key2, key1, key0}
//   mm_ram_addr_i   node write address
//   mm_ram_write_i  node write strobe
//   in_data_i       {addr, key}, addr in the MSBs
//   in_bypass_i     opaque sideband, delayed alongside the lookup
//   in_valid_i      lookup qualifier
//   out_data_o      {next_addr, key}
//   out_bypass_o    delayed in_bypass_i
//   out_valid_o     delayed in_valid_i
//
// Flow control: valid-only, no ready. A lookup is taken on every rising edge
// where in_valid_i=1 and reappears with out_valid_o=1 exactly
// 2 + RAM_OUT_REG_ENABLE + STAGE0_OUT_REG_ENABLE + STAGE1_OUT_REG_ENABLE
// edges later, in order. Data and bypass are registered every cycle and are
// meaningless while the matching valid is 0.
module qtree_level_stage #(
  parameter int ADDR_WIDTH            = 8,
  parameter int KEY_WIDTH             = 16,
  parameter int DATA_WIDTH            = 24,
  parameter int BYPASS_WIDTH          = 1,
  parameter int RAM_ADDR_WIDTH        = 2,
  parameter int RAM_DATA_WIDTH        = 48,
  parameter int RAM_OUT_REG_ENABLE    = 0,
  parameter int STAGE0_OUT_REG_ENABLE = 0,
  parameter int STAGE1_OUT_REG_ENABLE = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [RAM_DATA_WIDTH-1:0] mm_ram_data_i,
  input  logic [RAM_ADDR_WIDTH-1:0] mm_ram_addr_i,
  input  logic                      mm_ram_write_i,
  input  logic [DATA_WIDTH-1:0]     in_data_i,
  input  logic [BYPASS_WIDTH-1:0]   in_bypass_i,
  input  logic                      in_valid_i,
  output logic [DATA_WIDTH-1:0]     out_data_o,
  output logic [BYPASS_WIDTH-1:0]   out_bypass_o,
  output logic                      out_valid_o
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

  // ---------------------------------------------------------------------------
  // Node RAM. Words are stored inverted so that an array that powers up as
  // zeros reads back as all ones. The RAM is never reset.
  // ---------------------------------------------------------------------------
  logic [RAM_DATA_WIDTH-1:0] mem_inv [RAM_DEPTH];
  logic [RAM_DATA_WIDTH-1:0] rd_word_q;

  always_ff @(posedge clk_i) begin
    if (mm_ram_write_i) begin
      mem_inv[mm_ram_addr_i] <= ~mm_ram_data_i;
    end
  end

  // Read register: a same-cycle write to the same word is not yet visible
  // here, so the lookup sees the old contents.
  always_ff @(posedge clk_i) begin
    rd_word_q <= ~mem_inv[in_data_i[KEY_WIDTH +: RAM_ADDR_WIDTH]];
  end

  // Lookup fields travel alongside the RAM read.
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [BYPASS_WIDTH-1:0] rd_byp_q;
  logic                    rd_valid_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data_q  <= '0;
      rd_byp_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= in_data_i;
      rd_byp_q   <= in_bypass_i;
      rd_valid_q <= in_valid_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional register on the RAM read data (and its aligned lookup fields).
  // ---------------------------------------------------------------------------
  logic [RAM_DATA_WIDTH-1:0] cmp_word;
  logic [DATA_WIDTH-1:0]     cmp_data;
  logic [BYPASS_WIDTH-1:0]   cmp_byp;
  logic                      cmp_valid;

  if (RAM_OUT_REG_ENABLE != 0) begin : g_ram_out_reg
    logic [RAM_DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [BYPASS_WIDTH-1:0]   byp_q;
    logic                      valid_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        word_q  <= '0;
        data_q  <= '0;
        byp_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        word_q  <= rd_word_q;
        data_q  <= rd_data_q;
        byp_q   <= rd_byp_q;
        valid_q <= rd_valid_q;
      end
    end

    assign cmp_word  = word_q;
    assign cmp_data  = data_q;
    assign cmp_byp   = byp_q;
    assign cmp_valid = valid_q;
  end else begin : g_ram_out_pass
    assign cmp_word  = rd_word_q;
    assign cmp_data  = rd_data_q;
    assign cmp_byp   = rd_byp_q;
    assign cmp_valid = rd_valid_q;
  end

  // ---------------------------------------------------------------------------
  // Compare: child = number of node keys that the lookup key reaches.
  // Counting (rather than priority-decoding) keeps the result defined even
  // when software leaves the node keys unsorted.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] cmp_addr;
  logic [KEY_WIDTH-1:0]  cmp_key;
  logic [KEY_WIDTH-1:0]  node_key0;
  logic [KEY_WIDTH-1:0]  node_key1;
  logic [KEY_WIDTH-1:0]  node_key2;
  logic [1:0]            child;
  logic [DATA_WIDTH-1:0] cmp_out_data;
  logic                  unused_addr_msbs;

  assign {cmp_addr, cmp_key} = cmp_data;
  assign node_key0 = cmp_word[0*KEY_WIDTH +: KEY_WIDTH];
  assign node_key1 = cmp_word[1*KEY_WIDTH +: KEY_WIDTH];
  assign node_key2 = cmp_word[2*KEY_WIDTH +: KEY_WIDTH];

  assign child = 2'(cmp_key >= node_key0)
               + 2'(cmp_key >= node_key1)
               + 2'(cmp_key >= node_key2);

  // Shifting the child in drops the two address MSBs.
  assign cmp_out_data     = {cmp_addr[ADDR_WIDTH-3:0], child, cmp_key};
  assign unused_addr_msbs = ^cmp_addr[ADDR_WIDTH-1 -: 2];

  // ---------------------------------------------------------------------------
  // Optional register after the compare.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   out_data_d;
  logic [BYPASS_WIDTH-1:0] out_byp_d;
  logic                    out_valid_d;

  if (STAGE0_OUT_REG_ENABLE != 0) begin : g_stage0_reg
    logic [DATA_WIDTH-1:0]   data_q;
    logic [BYPASS_WIDTH-1:0] byp_q;
    logic                    valid_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        data_q  <= '0;
        byp_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= cmp_out_data;
        byp_q   <= cmp_byp;
        valid_q <= cmp_valid;
      end
    end

    assign out_data_d  = data_q;
    assign out_byp_d   = byp_q;
    assign out_valid_d = valid_q;
  end else begin : g_stage0_pass
    assign out_data_d  = cmp_out_data;
    assign out_byp_d   = cmp_byp;
    assign out_valid_d = cmp_valid;
  end

  // ---------------------------------------------------------------------------
  // Output register (always present).
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [BYPASS_WIDTH-1:0] out_byp_q;
  logic                    out_valid_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_data_q  <= '0;
      out_byp_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_byp_q   <= out_byp_d;
      out_valid_q <= out_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional extra output register.
  // ---------------------------------------------------------------------------
  if (STAGE1_OUT_REG_ENABLE != 0) begin : g_stage1_reg
    logic [DATA_WIDTH-1:0]   data_q;
    logic [BYPASS_WIDTH-1:0] byp_q;
    logic                    valid_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
        data_q  <= '0;
        byp_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        data_q  <= out_data_q;
        byp_q   <= out_byp_q;
        valid_q <= out_valid_q;
      end
    end

    assign out_data_o   = data_q;
    assign out_bypass_o = byp_q;
    assign out_valid_o  = valid_q;
  end else begin : g_stage1_pass
    assign out_data_o   = out_data_q;
    assign out_bypass_o = out_byp_q;
    assign out_valid_o  = out_valid_q;
  end

endmodule

// File: tb/tb_qtree_level_stage.sv
// Bench for qtree_level_stage. Two instances share the same stimulus: one with
// default parameters (latency 2) and one with every optional register enabled
// (latency 5). A node-key model plus one expected-output queue per instance
// predict each cycle's outputs.
module tb_qtree_level_stage;

  localparam int KW  = 16;
  localparam int AW  = 8;
  localparam int DW  = 24;
  localparam int RDW = 48;
  localparam int W   = DW + 2;  // {valid, bypass, data}

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [RDW-1:0] wr_data;
  logic [1:0]     wr_addr;
  logic           wr_en;
  logic [DW-1:0]  in_data;
  logic           in_byp;
  logic           in_valid;

  logic [DW-1:0]  a_data, b_data;
  logic           a_byp, b_byp;
  logic           a_valid, b_valid;

  qtree_level_stage dut_a (
    .clk_i(clk), .rst_i(rst_n),
    .mm_ram_data_i(wr_data), .mm_ram_addr_i(wr_addr), .mm_ram_write_i(wr_en),
    .in_data_i(in_data), .in_bypass_i(in_byp), .in_valid_i(in_valid),
    .out_data_o(a_data), .out_bypass_o(a_byp), .out_valid_o(a_valid)
  );

  qtree_level_stage #(
    .RAM_OUT_REG_ENABLE(1), .STAGE0_OUT_REG_ENABLE(1), .STAGE1_OUT_REG_ENABLE(1)
  ) dut_b (
    .clk_i(clk), .rst_i(rst_n),
    .mm_ram_data_i(wr_data), .mm_ram_addr_i(wr_addr), .mm_ram_write_i(wr_en),
    .in_data_i(in_data), .in_bypass_i(in_byp), .in_valid_i(in_valid),
    .out_data_o(b_data), .out_bypass_o(b_byp), .out_valid_o(b_valid)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------------
  logic [W-1:0] exp_q[$];   // latency-2 instance
  logic [W-1:0] exp5_q[$];  // latency-5 instance
  int unsigned  model_key [4][3];
  int           n_vec = 0;
  int           n_err = 0;

  function automatic int ref_child(input int unsigned key, input int node);
    int c = 0;
    for (int j = 0; j < 3; j++) if (key >= model_key[node][j]) c++;
    return c;
  endfunction

  task automatic check_out(input string tag, input logic [W-1:0] e,
                           input logic v, input logic b, input logic [DW-1:0] d);
    n_vec++;
    assert (v === e[W-1]) else begin
      n_err++;
      $error("FAIL %s valid got %0b exp %0b", tag, v, e[W-1]);
    end
    if (e[W-1]) begin
      n_vec++;
      assert (d === e[DW-1:0]) else begin
        n_err++;
        $error("FAIL %s data got %h exp %h", tag, d, e[DW-1:0]);
      end
      n_vec++;
      assert (b === e[DW]) else begin
        n_err++;
        $error("FAIL %s bypass got %0b exp %0b", tag, b, e[DW]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    n_vec++;
    assert ({a_valid, a_byp, a_data, b_valid, b_byp, b_data} === '0) else begin
      n_err++;
      $error("FAIL %s reset outputs got a=%0b/%0b/%h b=%0b/%0b/%h exp all zero",
             tag, a_valid, a_byp, a_data, b_valid, b_byp, b_data);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus, then check both instances.
  // exp_na >= 0 overrides the model with a hand-computed next address.
  // ---------------------------------------------------------------------------
  task automatic step(input logic we, input logic [1:0] wa, input logic [RDW-1:0] wd,
                      input logic v, input logic [AW-1:0] a, input logic [KW-1:0] k,
                      input logic b, input int exp_na);
    logic [W-1:0]  e;
    logic [AW-1:0] na;
    int            c;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    in_valid = v;
    in_data  = {a, k};
    in_byp   = b;
    // Lookup sees the node as it was before any write in this same cycle.
    c  = ref_child(k, int'(a) % 4);
    na = AW'((int'(a) * 4 + c) % 256);
    if (exp_na >= 0) na = AW'(exp_na);
    e = {v, b, na, k};
    exp_q.push_back(e);
    exp5_q.push_back(e);
    if (we) for (int j = 0; j < 3; j++) model_key[wa][j] = wd[j*KW +: KW];
    @(posedge clk);
    #1;
    if (exp_q.size() == 2) e = exp_q.pop_front(); else e = '0;
    check_out("lat2", e, a_valid, a_byp, a_data);
    if (exp5_q.size() == 5) e = exp5_q.pop_front(); else e = '0;
    check_out("lat5", e, b_valid, b_byp, b_data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, '0, 1'b0, 8'd0, 16'd0, 1'b0, -1);
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic [KW-1:0] k,
                        input logic b, input int exp_na);
    step(1'b0, 2'd0, '0, 1'b1, a, k, b, exp_na);
  endtask

  task automatic write_node(input logic [1:0] wa, input logic [RDW-1:0] wd);
    step(1'b1, wa, wd, 1'b0, 8'd0, 16'd0, 1'b0, -1);
  endtask

  // ---------------------------------------------------------------------------
  // Directed and random sequence
  // ---------------------------------------------------------------------------
  int          key_tab [6] = '{50, 100, 199, 200, 300, 65535};
  int          na_tab  [6] = '{4, 5, 5, 6, 7, 7};
  logic [RDW-1:0] node1;

  initial begin
    for (int n = 0; n < 4; n++) for (int j = 0; j < 3; j++) model_key[n][j] = 65535;
    node1    = {16'd300, 16'd200, 16'd100};
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    in_valid = 1'b0;
    in_data  = '0;
    in_byp   = 1'b0;

    // Reset state.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("por");
    end
    rst_n = 1'b1;

    // Establish known node contents (all ones), then node 1.
    for (int n = 0; n < 4; n++) write_node(2'(n), '1);
    write_node(2'd1, node1);

    // Key sweep on node 1, first one isolated.
    lookup(8'd1, 16'(key_tab[0]), 1'b0, na_tab[0]);
    idle(5);
    for (int i = 1; i < 6; i++) lookup(8'd1, 16'(key_tab[i]), 1'b0, na_tab[i]);
    idle(5);

    // Back-to-back with alternating bypass.
    for (int i = 0; i < 4; i++) lookup(8'd1, 16'd150, 1'(i % 2), 5);
    idle(5);

    // Same-cycle write and lookup of node 2: old data, then new data.
    step(1'b1, 2'd2, {16'd3, 16'd2, 16'd1}, 1'b1, 8'd2, 16'd2, 1'b0, 8);
    lookup(8'd2, 16'd2, 1'b1, 10);
    idle(5);

    // Address MSBs fall off.
    lookup(8'hC1, 16'd250, 1'b0, 8'h06);
    idle(5);

    // Random traffic with concurrent writes.
    for (int i = 0; i < 300; i++) begin
      logic [KW-1:0]  k0, k1, k2, t, k;
      logic [AW-1:0]  a;
      logic           we, v;
      logic [1:0]     wa;
      we = ($urandom_range(0, 3) == 0);
      wa = 2'($urandom_range(0, 3));
      k0 = 16'($urandom_range(0, 65535));
      k1 = 16'($urandom_range(0, 65535));
      k2 = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) begin
        if (k0 > k1) begin t = k0; k0 = k1; k1 = t; end
        if (k1 > k2) begin t = k1; k1 = k2; k2 = t; end
        if (k0 > k1) begin t = k0; k0 = k1; k1 = t; end
      end
      v = ($urandom_range(0, 3) != 0);
      a = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: k = 16'($urandom_range(0, 65535));
        1: k = 16'(model_key[int'(a) % 4][$urandom_range(0, 2)]);
        2: k = 16'(model_key[int'(a) % 4][$urandom_range(0, 2)]) - 16'd1;
        default: k = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'hFFFF;
      endcase
      step(we, wa, {k2, k1, k0}, v, a, k, 1'($urandom_range(0, 1)), -1);
    end
    idle(5);

    // Reset with lookups in flight.
    write_node(2'd1, node1);
    lookup(8'd1, 16'd100, 1'b1, 5);
    lookup(8'd1, 16'd300, 1'b0, 7);
    rst_n = 1'b0;
    #1;
    check_zero("rst_async");
    exp_q.delete();
    exp5_q.delete();
    in_valid = 1'b1;
    in_data  = {8'd1, 16'd200};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    idle(6);
    lookup(8'd1, 16'd200, 1'b1, 6);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
